// File: rtl/morse_key_decoder_if.sv
// Key input and decoded-frame outputs of the Morse key decoder.
// The decoder takes the slave side; whoever drives the key and consumes frames takes master.
interface morse_key_decoder_if;
  logic       key;
  logic [4:0] signal;
  logic [4:0] signal2;
  logic [4:0] signal3;
  logic [4:0] signal4;
  logic       code_valid;
  logic       code_err;
  logic       busy;

  modport master (
    output key,
    input  signal, signal2, signal3, signal4, code_valid, code_err, busy
  );

  modport slave (
    input  key,
    output signal, signal2, signal3, signal4, code_valid, code_err, busy
  );
endinterface

// File: rtl/morse_key_decoder.sv
// Decodes short/long key presses into four 5-bit symbols per frame, matching the
// LED pattern transmitter's codes; a completed frame is presented with a one-cycle strobe.
module morse_key_decoder #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int LONG_CYC     = 20,
  parameter int TIMEOUT_CYC  = 100,
  parameter int CW           = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  morse_key_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state, state_next;
  logic          key_m, key_s, key_db;
  logic [CW-1:0] db_cnt, dur_cnt, gap_cnt;
  logic [3:0]    sym_sh;
  logic [2:0]    elem_cnt;
  logic [1:0]    sym_cnt;
  logic [4:0]    shadow [4];
  logic [4:0]    out0, out1, out2, out3;
  logic          valid_q, err_q;

  logic          start_press, elem_done, elem, sym_done, frame_done, timeout;
  logic [4:0]    new_sym;

  // The raw key is synchronised, then only allowed to change the debounced level
  // after it has disagreed with it for DEBOUNCE_CYC consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m  <= 1'b0;
      key_s  <= 1'b0;
      key_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      key_m <= bus.key;
      key_s <= key_m;
      if (key_s == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        key_db <= ~key_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_db) state_next = PRESS;
      PRESS:   if (!key_db) state_next = frame_done ? IDLE : GAP;
      GAP: begin
        if (key_db)       state_next = PRESS;
        else if (timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A rise seen in GAP takes priority over a timeout on the same cycle.
  always_comb begin
    start_press = (state == IDLE || state == GAP) && key_db;
    elem_done   = (state == PRESS) && !key_db;
    elem        = (dur_cnt >= CW'(LONG_CYC));
    new_sym     = {sym_sh, elem};
    sym_done    = elem_done && (elem_cnt == 3'd4);
    frame_done  = sym_done && (sym_cnt == 2'd3);
    timeout     = (state == GAP) && !key_db && (gap_cnt == CW'(TIMEOUT_CYC - 1));
  end

  // The cycle that starts a press already counts as one cycle of duration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (start_press)
        dur_cnt <= CW'(1);
      else if (state == PRESS && key_db && dur_cnt < CW'(LONG_CYC))
        dur_cnt <= dur_cnt + 1'b1;

      if (elem_done)
        gap_cnt <= '0;
      else if (state == GAP && !key_db && !timeout)
        gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_sh   <= '0;
      elem_cnt <= '0;
      sym_cnt  <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else if (timeout) begin
      sym_sh   <= '0;
      elem_cnt <= '0;
      sym_cnt  <= '0;
    end else if (elem_done) begin
      if (sym_done) begin
        shadow[sym_cnt] <= new_sym;
        sym_sh          <= '0;
        elem_cnt        <= '0;
        sym_cnt         <= sym_cnt + 1'b1;
      end else begin
        sym_sh   <= new_sym[3:0];
        elem_cnt <= elem_cnt + 1'b1;
      end
    end
  end

  // The fourth symbol bypasses its shadow slot so the frame appears on the completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0    <= '0;
      out1    <= '0;
      out2    <= '0;
      out3    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= frame_done;
      err_q   <= timeout;
      if (frame_done) begin
        out0 <= shadow[0];
        out1 <= shadow[1];
        out2 <= shadow[2];
        out3 <= new_sym;
      end
    end
  end

  assign bus.signal     = out0;
  assign bus.signal2    = out1;
  assign bus.signal3    = out2;
  assign bus.signal4    = out3;
  assign bus.code_valid = valid_q;
  assign bus.code_err   = err_q;
  assign bus.busy       = (elem_cnt != 3'd0) || (sym_cnt != 2'd0);

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Receive-side counterpart of the LED long/short pattern transmitter: decodes operator key presses into the same four 5-bit codes the transmitter blinks out.
- A short press is element 0; a long press is element 1.
- Five elements form one symbol; four symbols form one frame.
- Sits between the board push-button and the passcode compare logic; presents a completed frame on signal/signal2/signal3/signal4 with a one-cycle valid strobe.

Parameters:
- DEBOUNCE_CYC, 4, consecutive stable cycles required before the debounced key changes level.
- LONG_CYC, 20, debounced-high cycles at or above which a press is a long element (1).
- TIMEOUT_CYC, 100, debounced-low cycles mid-frame after which the partial frame is discarded.
- CW, 8, width of the internal duration/gap counters; must hold max(DEBOUNCE_CYC, LONG_CYC, TIMEOUT_CYC).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key  input  1  raw push-button, asynchronous, active-high.
- signal  output  5  symbol 0 of last complete frame.
- signal2  output  5  symbol 1.
- signal3  output  5  symbol 2.
- signal4  output  5  symbol 3.
- code_valid  output  1  one-cycle pulse when a new frame is loaded onto signal..signal4.
- code_err  output  1  one-cycle pulse when a partial frame is discarded on timeout.
- busy  output  1  high while a frame is partially entered (elem_cnt or sym_cnt nonzero).

Behaviour:
- Reset (rst_n=0, async):
  - All outputs are 0.
  - Sync flops, key_db, counters, shift register and FSM are cleared; FSM goes to IDLE.
  - Asserting reset mid-frame discards the partial frame with no code_err.
- Input conditioning:
  - 2-FF synchroniser on key produces key_s.
  - Debounce counter increments while key_s != key_db and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC, key_db toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC cycles never reach key_db.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: on key_db rising, go to PRESS and clear dur_cnt.
  - PRESS:
    - dur_cnt increments each cycle key_db=1 and saturates at LONG_CYC.
    - On key_db falling: elem = (dur_cnt >= LONG_CYC), counting the rise cycle as 1.
    - Shift elem into sym_sh = {sym_sh[3:0], elem}, so the first element lands in bit 4; increment elem_cnt; go to GAP and clear gap_cnt.
  - GAP:
    - gap_cnt increments each cycle key_db=0.
    - On key_db rising, go to PRESS.
    - If gap_cnt reaches TIMEOUT_CYC: pulse code_err, clear sym_sh/elem_cnt/sym_cnt, go to IDLE.
- Symbol completion: on the cycle elem_cnt would reach 5:
  - Write the 5-bit symbol into shadow slot sym_cnt (0..3).
  - Clear elem_cnt and increment sym_cnt.
- Frame completion: when the 4th symbol is written:
  - In the same edge, copy the shadows to signal..signal4.
  - Assert code_valid for exactly one cycle; clear sym_cnt; go to IDLE (not GAP, so no timeout fires).
- Output hold:
  - signal..signal4 change only on frame completion or reset.
  - A timeout leaves the previous frame's outputs untouched.
- Latency: code_valid rises 1 clk after the edge where key_db falls for the 20th element. That is 2 (sync) + DEBOUNCE_CYC + 1 cycles after raw key falls.
- Simultaneous events:
  - A timeout and key_db rising on the same cycle: the rise wins and no code_err fires.
  - A press beginning in IDLE after a timeout starts a fresh frame.
- Widths: dur_cnt and gap_cnt saturate at their thresholds, so there is no wrap-around. elem_cnt is 3 bits; sym_cnt is 2 bits plus a completion compare.
- Expected size: ~150–250 lines of RTL.

Test Plan:
- Reset: hold rst_n=0 with key toggling -> all outputs 0; release rst_n -> outputs stay 0, busy=0.
- Full frame, defaults, short=10 raw cycles high, long=40, inter-press gap=20, entering 01011,10110,10101,10111 MSB-first -> outputs as follows:
  - signal=5'b01011, signal2=5'b10110, signal3=5'b10101, signal4=5'b10111.
  - code_valid high for exactly 1 cycle, 7 cycles after the final raw key fall.
  - code_err never asserted.
- Threshold boundary: debounced-high width of exactly 20 cycles -> element 1; 19 cycles -> element 0; 2-cycle raw glitch -> no element, elem_cnt unchanged.
- Timeout: enter 3 elements of a frame, then hold key low for 150 cycles:
  - code_err pulses once, ~100 cycles after the last debounced fall; busy falls.
  - signal..signal4 keep the previous frame.
  - A following complete frame 00000,11111,00000,11111 decodes correctly.
- Reset mid-frame: pull rst_n low after 12 elements -> outputs 0, no code_err; a new full frame afterwards decodes correctly.
- Very long press of 500 cycles followed by 19 short presses -> signal=5'b10000, signal2..signal4 = 0, and one code_valid.
